// File: rtl/dcache_ctrl.sv
// ---------------------------------------------------------------------------
// dcache_ctrl
//
// Purpose:
//   Sequencing controller for the M-stage data cache (write-through,
//   no-write-allocate). The tag/data arrays live outside this block. This
//   block:
//     - turns the external tag-compare result into a miss decision,
//     - refills a whole line over the request/ack main-memory port,
//     - forwards stores to memory,
//     - drives the array write strobes.
//   It also produces cache_ready, which the hazard unit uses to stall F/D/E/M.
//
// Parameters:
//   LINE_WORDS  words per line (power of 2, >= 2)
//   ADDR_W      byte address width
//   DATA_W      word width
//
// Ports:
//   CLK, RESETn            rising-edge clock, asynchronous active-low reset
//   MemtoRegM, MemWriteM   M-stage load / store (store wins if both are set)
//   AddrM, WriteDataM      M-stage byte address and store data
//   tag_hit                external valid & tag match for AddrM
//   cache_ready            0 = stall the pipeline
//   mem_req, mem_we        memory request and write qualifier
//   mem_addr, mem_wdata    word-aligned request address and write data
//   mem_ack, mem_rdata     memory accept/complete and read data
//   refill_we, refill_word data-array refill strobe and word index
//   line_addr              latched line base (refill) or word address (store)
//   tag_we                 write tag and set valid for line_addr
//   store_we               update data array with the store data (store hit)
//
// Optional feature (macro DCACHE_PERF_CNT_EN):
//   Adds three saturating 32-bit counters:
//     perf_rd_miss  load misses
//     perf_rd_hit   zero-penalty load hits
//     perf_wr       stores
// ---------------------------------------------------------------------------
module dcache_ctrl #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  localparam int WORD_IDX_W = $clog2(LINE_WORDS)
) (
  input  logic                  CLK,
  input  logic                  RESETn,
  input  logic                  MemtoRegM,
  input  logic                  MemWriteM,
  input  logic [ADDR_W-1:0]     AddrM,
  input  logic [DATA_W-1:0]     WriteDataM,
  input  logic                  tag_hit,
  output logic                  cache_ready,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  refill_we,
  output logic [WORD_IDX_W-1:0] refill_word,
  output logic [ADDR_W-1:0]     line_addr,
  output logic                  tag_we,
  output logic                  store_we
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]           perf_rd_miss,
  output logic [31:0]           perf_rd_hit,
  output logic [31:0]           perf_wr
`endif
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REFILL = 2'd1;
  localparam logic [1:0] WRITE  = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  // Byte-offset bits within a line; these are cleared to form the line base.
  localparam int OFFSET_W = WORD_IDX_W + 2;
  localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << OFFSET_W;
  localparam logic [WORD_IDX_W-1:0] LAST_WORD = WORD_IDX_W'(LINE_WORDS - 1);

  logic [1:0]            state;
  logic [WORD_IDX_W-1:0] cnt;
  logic [DATA_W-1:0]     wdata_q;

  logic is_store;
  logic is_load_hit;
  logic is_load_miss;
  logic last_word;

  // Refill data goes straight from memory into the external data array, so
  // the controller never looks at it.
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata;

  // A store always takes priority over a simultaneous load.
  assign is_store     = MemWriteM;
  assign is_load_hit  = MemtoRegM & ~MemWriteM &  tag_hit;
  assign is_load_miss = MemtoRegM & ~MemWriteM & ~tag_hit;
  assign last_word    = (cnt == LAST_WORD);

  // Sequencing state. A reset abandons any refill in progress; because the
  // tag is only written with the last word, the line stays invalid.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state     <= IDLE;
      cnt       <= '0;
      line_addr <= '0;
      wdata_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (is_store) begin
            line_addr <= {AddrM[ADDR_W-1:2], 2'b00};
            wdata_q   <= WriteDataM;
            state     <= WRITE;
          end else if (is_load_miss) begin
            line_addr <= AddrM & LINE_MASK;
            cnt       <= '0;
            state     <= REFILL;
          end
        end
        REFILL: begin
          if (mem_ack) begin
            // Power-of-2 line length makes the increment wrap to 0 on the
            // last word.
            cnt <= cnt + WORD_IDX_W'(1);
            if (last_word) begin
              state <= DONE;
            end
          end
        end
        WRITE: begin
          if (mem_ack) begin
            state <= DONE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Output decode. The stall in IDLE is combinational, so a miss stalls the
  // pipeline in the very cycle it is detected; DONE releases the stall for
  // the one cycle in which the M instruction retires.
  always_comb begin
    cache_ready = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = line_addr;
    refill_we   = 1'b0;
    tag_we      = 1'b0;
    store_we    = 1'b0;
    case (state)
      IDLE: begin
        cache_ready = ~(is_store | is_load_miss);
      end
      REFILL: begin
        mem_req   = 1'b1;
        mem_addr  = line_addr + ADDR_W'({cnt, 2'b00});
        refill_we = mem_ack;
        tag_we    = mem_ack & last_word;
      end
      WRITE: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        store_we = mem_ack & tag_hit;
      end
      default: begin
        cache_ready = 1'b1;
      end
    endcase
  end

  assign mem_wdata   = wdata_q;
  assign refill_word = cnt;

`ifdef DCACHE_PERF_CNT_EN
  // Event counters; each one holds at all-ones instead of wrapping.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      perf_rd_miss <= '0;
      perf_rd_hit  <= '0;
      perf_wr      <= '0;
    end else if (state == IDLE) begin
      if (is_store) begin
        if (perf_wr != '1) perf_wr <= perf_wr + 32'd1;
      end else if (is_load_miss) begin
        if (perf_rd_miss != '1) perf_rd_miss <= perf_rd_miss + 32'd1;
      end else if (is_load_hit) begin
        if (perf_rd_hit != '1) perf_rd_hit <= perf_rd_hit + 32'd1;
      end
    end
  end
`else
  logic unused_hit;
  assign unused_hit = is_load_hit;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dcache_ctrl
//
// Purpose:
//   Self-checking bench for dcache_ctrl (LINE_WORDS = 4, default build).
//   The bench owns a valid-line table and derives tag_hit from it. Each
//   access pushes the memory transactions it should cause into a queue. A
//   memory responder/monitor process answers requests with
//   (fixed or random) wait states, then pops and compares each accepted
//   transaction. The stimulus process checks the stall length of every
//   access against the penalty rules.
// ---------------------------------------------------------------------------
module tb_dcache_ctrl;

  localparam int LW = 4;

  logic        CLK;
  logic        RESETn;
  logic        MemtoRegM;
  logic        MemWriteM;
  logic [31:0] AddrM;
  logic [31:0] WriteDataM;
  logic        tag_hit;
  logic        cache_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        refill_we;
  logic [1:0]  refill_word;
  logic [31:0] line_addr;
  logic        tag_we;
  logic        store_we;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  word;
    bit          tag_we;
    bit          store_we;
    logic [31:0] line;
  } exp_t;

  exp_t exp_q[$];
  bit   valid_line [int unsigned];

  int vectors;
  int miscompares;
  int wait_cfg;
  int wait_left;
  int waits_used;

  dcache_ctrl #(.LINE_WORDS(LW), .ADDR_W(32), .DATA_W(32)) dut (
    .CLK         (CLK),
    .RESETn      (RESETn),
    .MemtoRegM   (MemtoRegM),
    .MemWriteM   (MemWriteM),
    .AddrM       (AddrM),
    .WriteDataM  (WriteDataM),
    .tag_hit     (tag_hit),
    .cache_ready (cache_ready),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .refill_we   (refill_we),
    .refill_word (refill_word),
    .line_addr   (line_addr),
    .tag_we      (tag_we),
    .store_we    (store_we)
  );

  // Free-running 100 MHz-style clock.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Single comparison point: every check in the bench steps these counters.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Memory responder and scoreboard monitor. On each falling edge, decide
  // whether the pending request is acknowledged this cycle. Then compare the
  // DUT's request and strobes against the oldest expected transaction,
  // popping it once it is accepted.
  always @(negedge CLK) begin
    exp_t e;
    if (!RESETn || !mem_req) begin
      mem_ack   = 1'b0;
      wait_left = -1;
    end else begin
      if (wait_left < 0)
        wait_left = (wait_cfg >= 0) ? wait_cfg : int'($urandom_range(0, 2));
      if (wait_left == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = $urandom;
        wait_left = -1;
      end else begin
        mem_ack = 1'b0;
        wait_left--;
        waits_used++;
      end
    end
    #1;
    if (RESETn) begin
      if (mem_req) begin
        if (exp_q.size() == 0) begin
          checkOutput("req_expected", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q[0];
          checkOutput("mem_we", 32'(mem_we), 32'(e.we));
          checkOutput("mem_addr", mem_addr, e.addr);
          if (e.we) checkOutput("mem_wdata", mem_wdata, e.wdata);
          if (mem_ack) begin
            checkOutput("refill_we", 32'(refill_we), 32'(!e.we));
            if (!e.we) begin
              checkOutput("refill_word", 32'(refill_word), 32'(e.word));
              checkOutput("line_addr", line_addr, e.line);
            end
            checkOutput("tag_we", 32'(tag_we), 32'(e.tag_we));
            checkOutput("store_we", 32'(store_we), 32'(e.store_we));
            void'(exp_q.pop_front());
          end else begin
            checkOutput("strobes_wait", 32'({refill_we, tag_we, store_we}), 32'd0);
          end
        end
      end else begin
        checkOutput("strobes_idle", 32'({mem_we, refill_we, tag_we, store_we}), 32'd0);
      end
    end
  end

  // Present one access (or an idle cycle) and hold it until cache_ready.
  // Queue the expected memory traffic, then check the stall length:
  //   load hit / no access : 0 cycles
  //   load miss            : LW + 1 + wait states
  //   store                : 2 + wait states
  task automatic applyStimulus(input bit is_load, input bit is_store,
                               input logic [31:0] addr, input logic [31:0] data);
    bit   hit;
    bit   done;
    int   low;
    int   exp_low;
    exp_t e;
    logic [31:0] base;
    @(posedge CLK);
    #2;
    base       = addr & ~32'hF;
    hit        = valid_line.exists(addr >> 4);
    MemtoRegM  = is_load;
    MemWriteM  = is_store;
    AddrM      = addr;
    WriteDataM = data;
    tag_hit    = hit;
    waits_used = 0;
    if (is_store) begin
      e = '{we: 1'b1, addr: addr & ~32'h3, wdata: data, word: 2'd0,
            tag_we: 1'b0, store_we: hit, line: 32'd0};
      exp_q.push_back(e);
    end else if (is_load && !hit) begin
      for (int i = 0; i < LW; i++) begin
        e = '{we: 1'b0, addr: base + 32'(4 * i), wdata: 32'd0, word: 2'(i),
              tag_we: (i == LW - 1), store_we: 1'b0, line: base};
        exp_q.push_back(e);
      end
    end
    low  = 0;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge CLK);
      #2;
      if (cache_ready) done = 1'b1;
      else low++;
    end
    if (!done) begin
      checkOutput("ready_timeout", 32'(cache_ready), 32'd1);
      exp_q.delete();
    end
    if (is_store)            exp_low = 2 + waits_used;
    else if (is_load && !hit) exp_low = LW + 1 + waits_used;
    else                     exp_low = 0;
    checkOutput("stall_cycles", 32'(low), 32'(exp_low));
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
    if (!is_store && is_load && !hit) valid_line[addr >> 4] = 1'b1;
  endtask

  // Start a refill, take reset after two words have been accepted, and
  // confirm the abandoned line restarts from word 0 on the next miss.
  task automatic resetMidRefill(input logic [31:0] addr);
    exp_t e;
    logic [31:0] base;
    bit   seen;
    base = addr & ~32'hF;
    @(posedge CLK);
    #2;
    MemtoRegM = 1'b1;
    MemWriteM = 1'b0;
    AddrM     = addr;
    tag_hit   = 1'b0;
    for (int i = 0; i < LW; i++) begin
      e = '{we: 1'b0, addr: base + 32'(4 * i), wdata: 32'd0, word: 2'(i),
            tag_we: (i == LW - 1), store_we: 1'b0, line: base};
      exp_q.push_back(e);
    end
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge CLK);
      #2;
      if (exp_q.size() == LW - 2) seen = 1'b1;
    end
    checkOutput("two_acks_seen", 32'(exp_q.size()), 32'(LW - 2));
    @(posedge CLK);
    #1;
    RESETn = 1'b0;
    #1;
    checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
    checkOutput("rst_tag_we", 32'(tag_we), 32'd0);
    checkOutput("rst_refill_we", 32'(refill_we), 32'd0);
    checkOutput("rst_line_addr", line_addr, 32'd0);
    MemtoRegM = 1'b0;
    #1;
    checkOutput("rst_ready", 32'(cache_ready), 32'd1);
    exp_q.delete();
    @(posedge CLK);
    #3;
    RESETn = 1'b1;
    applyStimulus(1'b1, 1'b0, addr, 32'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    wait_cfg    = 0;
    wait_left   = -1;
    waits_used  = 0;
    RESETn      = 1'b0;
    MemtoRegM   = 1'b0;
    MemWriteM   = 1'b0;
    AddrM       = 32'd0;
    WriteDataM  = 32'd0;
    tag_hit     = 1'b0;
    mem_ack     = 1'b0;
    mem_rdata   = 32'd0;

    // Reset held: ready high, no strobes.
    repeat (3) @(negedge CLK);
    #2;
    checkOutput("reset_ready", 32'(cache_ready), 32'd1);
    checkOutput("reset_strobes",
                32'({mem_req, mem_we, refill_we, tag_we, store_we}), 32'd0);
    @(posedge CLK);
    #3;
    RESETn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      #2;
      checkOutput("idle_ready", 32'(cache_ready), 32'd1);
      checkOutput("idle_req", 32'(mem_req), 32'd0);
    end

    // Directed cases with zero-wait memory, then two wait states for stores.
    $display("[TB] directed load miss / hit");
    applyStimulus(1'b1, 1'b0, 32'h0000_010C, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0000_0100, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0000_0204, 32'd0);
    $display("[TB] directed stores with two wait states");
    wait_cfg = 2;
    applyStimulus(1'b0, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 1'b1, 32'h0000_0300, 32'hDEAD_BEEF);
    applyStimulus(1'b1, 1'b0, 32'h0000_0304, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);

    $display("[TB] reset during refill");
    wait_cfg = 0;
    resetMidRefill(32'h0000_0408);

    // Randomized traffic over 16 lines with random wait states.
    $display("[TB] random traffic");
    wait_cfg = -1;
    for (int n = 0; n < 80; n++) begin
      int kind;
      logic [31:0] a;
      kind = int'($urandom_range(0, 3));
      a    = (32'($urandom_range(0, 15)) << 4) | (32'($urandom_range(0, 3)) << 2);
      applyStimulus(kind == 1 || kind == 2, kind == 3, a, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard stop so a stuck run still ends with a visible failure.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Sequencing controller for the M-stage data cache.
- Arrays are external. This block detects misses from an external tag-compare hit, runs multi-word line refills and write-through stores over a single request/ack main-memory port, and drives array write strobes.
- Produces `cache_ready`, which the hazard unit uses to stall F/D/E/M.
- Policy: write-through, no-write-allocate.

Parameters:
- `LINE_WORDS`, 4, words per cache line; power of 2, ≥2.
- `ADDR_W`, 32, byte address width.
- `DATA_W`, 32, word width.

Ports:
- `CLK`  in  1  clock, rising edge.
- `RESETn`  in  1  asynchronous active-low reset.
- `MemtoRegM`  in  1  M-stage load.
- `MemWriteM`  in  1  M-stage store.
- `AddrM`  in  ADDR_W  M-stage byte address.
- `WriteDataM`  in  DATA_W  store data.
- `tag_hit`  in  1  external valid&tag match for `AddrM`, combinational.
- `cache_ready`  out  1  0 = stall the pipeline.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  1 = write request.
- `mem_addr`  out  ADDR_W  word-aligned request address.
- `mem_wdata`  out  DATA_W  write data.
- `mem_ack`  in  1  request accepted/completed this cycle.
- `mem_rdata`  in  DATA_W  read data, valid with `mem_ack` on reads.
- `refill_we`  out  1  write `mem_rdata` into the data array.
- `refill_word`  out  log2(LINE_WORDS)  word index for `refill_we`.
- `line_addr`  out  ADDR_W  latched line base address for the array index/tag.
- `tag_we`  out  1  write tag and set valid for `line_addr`.
- `store_we`  out  1  update the data array with `WriteDataM` (store hit).

Behaviour:
- **States:** IDLE, REFILL, WRITE, DONE. Registered state, counter `cnt`, `line_addr`, `wdata_q`.
- **Reset (RESETn=0, asynchronous, any state):**
  - State goes to IDLE; `cnt`, `line_addr`, `wdata_q` go to 0.
  - All strobes (`mem_req`, `mem_we`, `refill_we`, `tag_we`, `store_we`) are 0.
  - `cache_ready` = 1 in IDLE with no access.
  - An in-flight refill is abandoned: no `tag_we`, line stays invalid.
- **IDLE:**
  - No access: `cache_ready` = 1.
  - Load with `tag_hit` = 1: `cache_ready` = 1, no state change. Zero-cycle penalty.
  - Load with `tag_hit` = 0: `cache_ready` = 0 combinationally. Latch line base (`AddrM` with the low log2(LINE_WORDS)+2 bits cleared), `cnt` ← 0, go to REFILL.
  - Store (hit or miss): `cache_ready` = 0. Latch word-aligned `AddrM` and `WriteDataM`, go to WRITE.
  - `MemtoRegM` and `MemWriteM` both 1 is illegal; the store takes priority.
- **REFILL:**
  - `mem_req` = 1, `mem_we` = 0, `mem_addr` = `line_addr` + 4·`cnt`. Held stable until `mem_ack`.
  - On `mem_ack`: `refill_we` = 1 and `refill_word` = `cnt` in the same cycle; `cnt` increments.
  - On `mem_ack` with `cnt` = LINE_WORDS−1: `tag_we` = 1 in that cycle, `cnt` wraps to 0, go to DONE.
  - `cache_ready` = 0 throughout.
- **WRITE:**
  - `mem_req` = 1, `mem_we` = 1, `mem_addr`/`mem_wdata` from the latched values.
  - On `mem_ack`: `store_we` = `tag_hit`, go to DONE. A miss does not allocate.
  - `cache_ready` = 0.
- **DONE:**
  - `cache_ready` = 1 for exactly one cycle; no memory request; return to IDLE.
  - The M instruction retires this cycle; the now-hitting load reads the array.
  - An access presented in DONE is not evaluated. It belongs to the retiring instruction.
- **Penalties (zero-wait memory, `mem_ack` in the first request cycle):**
  - Load miss: `cache_ready` low for LINE_WORDS+1 cycles.
  - Store: `cache_ready` low for 2 cycles.
- **Back-to-back:** a miss immediately after DONE starts a new sequence the next cycle.
- **Wait states:** `mem_ack` low indefinitely keeps the FSM in its state with outputs stable. There is no timeout.

Optional Feature:
- Macro: `DCACHE_PERF_CNT_EN`.
- **Defined:** adds outputs `perf_rd_miss` (32-bit, increments on each IDLE→REFILL), `perf_rd_hit` (32-bit, increments on each zero-penalty load hit in IDLE) and `perf_wr` (32-bit, increments on each IDLE→WRITE).
  - All three counters reset to 0 and saturate at all-ones.
- **Undefined:** these ports and registers are absent; behaviour is otherwise identical.

Test Plan:
- **Reset/idle:** hold RESETn=0 → `cache_ready`=1, all strobes 0. Release with no access → unchanged for 10 cycles.
- **Load hit:** `MemtoRegM`=1, `AddrM`=0x100, `tag_hit`=1 → `cache_ready`=1, `mem_req` stays 0.
- **Load miss, LINE_WORDS=4, zero-wait:** `AddrM`=0x10C, `tag_hit`=0 →
  - `mem_addr` = 0x100, 0x104, 0x108, 0x10C on consecutive cycles;
  - `refill_word` = 0..3 with `refill_we` each cycle;
  - `tag_we` with word 3, `line_addr`=0x100;
  - `cache_ready` low 5 cycles, then high 1 cycle.
- **Store hit with 2 wait states:** `MemWriteM`=1, `AddrM`=0x200, `WriteDataM`=0xDEADBEEF, `tag_hit`=1, `mem_ack` on the 3rd request cycle →
  - `mem_we`=1, `mem_wdata`=0xDEADBEEF, `mem_addr`=0x200 stable for 3 cycles;
  - `store_we` pulses once;
  - `cache_ready` low 4 cycles.
- **Store miss:** as above with `tag_hit`=0 → `store_we` and `tag_we` never assert.
- **Reset mid-refill:** assert RESETn=0 after 2 acks of a refill → immediate IDLE, `mem_req`=0, no `tag_we`. A following load to the same line with `tag_hit`=0 restarts at word 0.
